keypad_scanner: RTL and testbench

Input-side counterpart of the scanned 7-segment display. Drives a 4x4 matrix keypad one active-low column strobe at a time, in the same time-multiplexed way the display drives its anodes, and samples the active-low row lines. It debounces the sampled frames and reports each new single-key press as a 4-bit code with a one-cycle valid pulse. Sits between board keypad pins and clock-setting logic.

---
 rtl/keypad_scanner_pkg.sv | 35 +++
 rtl/keypad_frame_decoder.sv | 33 +++
 rtl/keypad_scanner.sv | 155 +++++++++++++++
 tb/tb_keypad_scanner.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_scanner_pkg;

    localparam int unsigned KILO     = 1000;
    localparam int unsigned NUM_KEYS = 16;
    localparam int unsigned KEY_W    = 4;
    localparam int unsigned COL_W    = 4;
    localparam int unsigned ROW_W    = 4;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned CNT_MAX  = 15;

    typedef enum logic [1:0] {
        KP_NONE  = 2'd0,
        KP_ONE   = 2'd1,
        KP_MULTI = 2'd2
    } frame_class_e;

    typedef enum logic [1:0] {
        KP_IDLE    = 2'd0,
        KP_PRESS   = 2'd1,
        KP_HELD    = 2'd2,
        KP_RELEASE = 2'd3
    } kp_state_e;

    typedef struct packed {
        frame_class_e     cls;
        logic [KEY_W-1:0] idx;
    } frame_info_t;

    // Advance the active-low column strobe: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
    function automatic logic [COL_W-1:0] rotate_col(input logic [COL_W-1:0] col);
        return {col[COL_W-2:0], col[COL_W-1]};
    endfunction

endpackage

// File: rtl/keypad_frame_decoder.sv
// Classifies a full 16-key snapshot as no key, exactly one key (with index) or several keys.
module keypad_frame_decoder
    import keypad_scanner_pkg::*;
(
    input  logic [NUM_KEYS-1:0] snapshot,
    output frame_info_t         info_c
);

    logic [4:0]       ones;
    logic [KEY_W-1:0] last;

    always_comb begin
        ones = 5'd0;
        last = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (snapshot[i]) begin
                ones = ones + 5'd1;
                last = KEY_W'(i);
            end
        end

        info_c.idx = '0;
        if (ones == 5'd0) begin
            info_c.cls = KP_NONE;
        end else if (ones == 5'd1) begin
            info_c.cls = KP_ONE;
            info_c.idx = last;
        end else begin
            info_c.cls = KP_MULTI;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column-strobed 4x4 keypad scanner with frame-level debounce; emits a one-cycle
// pulse and code for each newly accepted single-key press.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = KILO,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ROW_W-1:0] ROW,
    output logic [COL_W-1:0] COL,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam int unsigned DWELL   = ((CLK_FREQ_HZ / KILO) > 0) ? (CLK_FREQ_HZ / KILO) : 1;
    localparam int unsigned DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [CNT_W-1:0]   DEB_TARGET = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(CNT_MAX);
    localparam logic [COL_W-1:0]   COL_FIRST  = 4'b1110;

    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [NUM_KEYS-1:0] snap_q, snap_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    frame_class_e        prev_cls_q, prev_cls_d;
    logic [KEY_W-1:0]    prev_idx_q, prev_idx_d;
    kp_state_e           state_q, state_d;
    logic [KEY_W-1:0]    key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_held_q, key_held_d;

    logic        capture_c;
    logic        frame_end_c;
    logic        same_c;
    frame_info_t frame_c;

    // The decoder sees the merged snapshot, so column 3 counts in the frame it closes.
    keypad_frame_decoder u_decoder (
        .snapshot (snap_d),
        .info_c   (frame_c)
    );

    // Column scan, snapshot capture and stable-frame counting.
    always_comb begin
        dwell_d    = dwell_q + DWELL_W'(1);
        col_d      = col_q;
        col_idx_d  = col_idx_q;
        snap_d     = snap_q;
        cnt_d      = cnt_q;
        prev_cls_d = prev_cls_q;
        prev_idx_d = prev_idx_q;

        capture_c   = (dwell_q == DWELL_LAST);
        frame_end_c = capture_c && (col_idx_q == 2'd3);
        same_c      = (frame_c.cls == prev_cls_q) &&
                      ((frame_c.cls != KP_ONE) || (frame_c.idx == prev_idx_q));

        if (capture_c) begin
            dwell_d                          = '0;
            col_d                            = rotate_col(col_q);
            col_idx_d                        = col_idx_q + 2'd1;
            snap_d[{col_idx_q, 2'b00} +: ROW_W] = ~ROW;
        end

        if (frame_end_c) begin
            if (same_c) begin
                cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                cnt_d = CNT_W'(1);
            end
            prev_cls_d = frame_c.cls;
            prev_idx_d = frame_c.idx;
        end
    end

    // Press/release state machine, stepped once per frame.
    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        if (frame_end_c) begin
            unique case (state_q)
                KP_IDLE, KP_PRESS: begin
                    if (frame_c.cls == KP_ONE) begin
                        if (cnt_d == DEB_TARGET) begin
                            state_d     = KP_HELD;
                            key_code_d  = frame_c.idx;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                        end else begin
                            state_d = KP_PRESS;
                        end
                    end else begin
                        state_d = KP_IDLE;
                    end
                end
                KP_HELD, KP_RELEASE: begin
                    if (frame_c.cls == KP_NONE) begin
                        if (cnt_d == DEB_TARGET) begin
                            state_d    = KP_IDLE;
                            key_held_d = 1'b0;
                        end else begin
                            state_d = KP_RELEASE;
                        end
                    end else begin
                        state_d = KP_HELD;
                    end
                end
                default: state_d = KP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dwell_q     <= '0;
            col_q       <= COL_FIRST;
            col_idx_q   <= 2'd0;
            snap_q      <= '0;
            cnt_q       <= '0;
            prev_cls_q  <= KP_NONE;
            prev_idx_q  <= '0;
            state_q     <= KP_IDLE;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            col_idx_q   <= col_idx_d;
            snap_q      <= snap_d;
            cnt_q       <= cnt_d;
            prev_cls_q  <= prev_cls_d;
            prev_idx_q  <= prev_idx_d;
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign COL       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: vector table, random frames against a frame-level model,
// and hand sequences for reset, slow dwell and single-scan debounce.
module tb_keypad_scanner;

    localparam int DS_A = 4;

    localparam logic [15:0] K0  = 16'h0001;
    localparam logic [15:0] K3  = 16'h0008;
    localparam logic [15:0] K5  = 16'h0020;
    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K15 = 16'h8000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, rst_c;
    logic [15:0] keys_a, keys_b, keys_c;
    logic [3:0]  row_a, row_b, row_c;
    logic [3:0]  col_a, col_b, col_c;
    logic [3:0]  code_a, code_b, code_c;
    logic        valid_a, valid_b, valid_c;
    logic        held_a, held_b, held_c;

    logic [3:0] cols_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Keypad matrix: a closed key pulls its row low while its column is driven.
    function automatic logic [3:0] row_of(input logic [15:0] keys, input logic [3:0] col);
        case (col)
            4'b1110: return ~keys[3:0];
            4'b1101: return ~keys[7:4];
            4'b1011: return ~keys[11:8];
            4'b0111: return ~keys[15:12];
            default: return 4'hF;
        endcase
    endfunction

    assign row_a = row_of(keys_a, col_a);
    assign row_b = row_of(keys_b, col_b);
    assign row_c = row_of(keys_c, col_c);

    keypad_scanner #(.CLK_FREQ_HZ(1000), .DEBOUNCE_SCANS(DS_A)) dut_a (
        .clk(clk), .reset(rst_a), .ROW(row_a), .COL(col_a),
        .key_code(code_a), .key_valid(valid_a), .key_held(held_a));

    keypad_scanner #(.CLK_FREQ_HZ(4000), .DEBOUNCE_SCANS(4)) dut_b (
        .clk(clk), .reset(rst_b), .ROW(row_b), .COL(col_b),
        .key_code(code_b), .key_valid(valid_b), .key_held(held_b));

    keypad_scanner #(.CLK_FREQ_HZ(1000), .DEBOUNCE_SCANS(1)) dut_c (
        .clk(clk), .reset(rst_c), .ROW(row_c), .COL(col_c),
        .key_code(code_c), .key_valid(valid_c), .key_held(held_c));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: run length of identical frame contents decides events.
    int m_prev, m_run, m_code;
    bit m_held;

    function automatic int classify(input logic [15:0] k);
        int n;
        n = $countones(k);
        if (n == 0) return 16;
        if (n > 1)  return 17;
        for (int i = 0; i < 16; i++) if (k[i]) return i;
        return 16;
    endfunction

    task automatic model_reset();
        m_prev = 16; m_run = 0; m_held = 0; m_code = 0;
    endtask

    task automatic model_frame(input logic [15:0] k, output bit pulse);
        int c;
        c      = classify(k);
        m_run  = (c == m_prev) ? m_run + 1 : 1;
        m_prev = c;
        pulse  = 0;
        if (!m_held && c < 16 && m_run == DS_A) begin
            pulse  = 1;
            m_held = 1;
            m_code = c;
        end else if (m_held && c == 16 && m_run == DS_A) begin
            m_held = 0;
        end
    endtask

    task automatic run_frame_a(input logic [15:0] k, output int pulses);
        bit p;
        pulses = 0;
        keys_a = k;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            p = 0;
            if (c == 3) model_frame(k, p);
            check("col_a",   int'(col_a),   int'(cols_tab[(c + 1) % 4]));
            check("valid_a", int'(valid_a), int'(p));
            check("held_a",  int'(held_a),  int'(m_held));
            check("code_a",  int'(code_a),  m_code);
            if (valid_a) pulses++;
        end
    endtask

    task automatic reset_a();
        rst_a  = 1'b0;
        keys_a = '0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_col_a",   int'(col_a),   4'b1110);
            check("rst_valid_a", int'(valid_a), 0);
            check("rst_held_a",  int'(held_a),  0);
            check("rst_code_a",  int'(code_a),  0);
        end
        rst_a = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [15:0] keys;
        int          frames;
        int          pulses;
        bit          held;
        int          code;
    } vec_t;

    vec_t tab [23];

    initial begin
        int  p, total, first;
        logic [15:0] k;

        tab[0]  = '{16'h0000,   2, 0, 1'b0, 0};
        tab[1]  = '{K9,         4, 1, 1'b1, 9};
        tab[2]  = '{16'h0000,   3, 0, 1'b1, 9};
        tab[3]  = '{K9,         2, 0, 1'b1, 9};
        tab[4]  = '{16'h0000,   4, 0, 1'b0, 9};
        tab[5]  = '{K0 | K5,    8, 0, 1'b0, 9};
        tab[6]  = '{16'h0000,   1, 0, 1'b0, 9};
        tab[7]  = '{K9,         4, 1, 1'b1, 9};
        tab[8]  = '{K9 | K3,    5, 0, 1'b1, 9};
        tab[9]  = '{K3,         5, 0, 1'b1, 9};
        tab[10] = '{16'h0000,   4, 0, 1'b0, 9};
        tab[11] = '{K3,         3, 0, 1'b0, 9};
        tab[12] = '{16'h0000,   1, 0, 1'b0, 9};
        tab[13] = '{K15,        4, 1, 1'b1, 15};
        tab[14] = '{16'h0000,   4, 0, 1'b0, 15};
        for (int i = 0; i < 3; i++) begin
            tab[15 + 2 * i] = '{K9,       2, 0, 1'b0, 15};
            tab[16 + 2 * i] = '{16'h0000, 2, 0, 1'b0, 15};
        end
        tab[21] = '{K9,       4, 1, 1'b1, 9};
        tab[22] = '{16'h0000, 4, 0, 1'b0, 9};

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        keys_a = '0; keys_b = K9; keys_c = '0;
        @(negedge clk);

        // Slow dwell: four cycles per column, reset after three stable frames.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_col_b", int'(col_b), 4'b1110);
        end
        rst_b = 1'b1;
        for (int n = 1; n <= 48; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("scan_col_b", int'(col_b), int'(cols_tab[(n / 4) % 4]));
            check("early_valid_b", int'(valid_b), 0);
        end
        rst_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_col_b",   int'(col_b),   4'b1110);
        check("midrst_valid_b", int'(valid_b), 0);
        check("midrst_held_b",  int'(held_b),  0);
        rst_b = 1'b1;
        first = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_b) begin
                first = n;
                break;
            end
        end
        check("pulse_cycle_b", first, 64);
        check("code_b", int'(code_b), 9);
        check("held_b", int'(held_b), 1);
        @(posedge clk);
        @(negedge clk);
        check("pulse_width_b", int'(valid_b), 0);
        rst_b = 1'b0;

        // Single-scan debounce: accept and release on the first qualifying frame.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_c  = 1'b1;
        keys_c = K5;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("valid_c", int'(valid_c), (n == 4) ? 1 : 0);
            check("held_c",  int'(held_c),  (n >= 4 && n < 8) ? 1 : 0);
            check("code_c",  int'(code_c),  (n >= 4) ? 5 : 0);
            if (n == 4) keys_c = '0;
        end
        rst_c = 1'b0;

        // Vector table on the fast-dwell instance.
        reset_a();
        foreach (tab[i]) begin
            total = 0;
            for (int f = 0; f < tab[i].frames; f++) begin
                run_frame_a(tab[i].keys, p);
                total += p;
            end
            check("tbl_pulses", total, tab[i].pulses);
            check("tbl_held",   int'(held_a), int'(tab[i].held));
            check("tbl_code",   int'(code_a), tab[i].code);
        end

        // Reset in the middle of a debounce, part-way through a frame.
        reset_a();
        total = 0;
        for (int f = 0; f < 3; f++) begin
            run_frame_a(K9, p);
            total += p;
        end
        keys_a = K9;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("part_col_a", int'(col_a), int'(cols_tab[c + 1]));
        end
        rst_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_col_a",   int'(col_a),   4'b1110);
        check("midrst_valid_a", int'(valid_a), 0);
        check("midrst_held_a",  int'(held_a),  0);
        rst_a = 1'b1;
        model_reset();
        for (int f = 0; f < 4; f++) begin
            run_frame_a(K9, p);
            total += p;
            check("post_rst_pulse", p, (f == 3) ? 1 : 0);
        end
        check("midrst_total", total, 1);

        // Random frame sequences against the reference model.
        for (int s = 0; s < 40; s++) begin
            int kind, len, a, b;
            kind = $urandom_range(0, 3);
            len  = $urandom_range(1, 6);
            a    = $urandom_range(0, 15);
            b    = (a + $urandom_range(1, 15)) % 16;
            k    = '0;
            if (kind == 1 || kind == 2) k[a] = 1'b1;
            if (kind == 3) begin
                k[a] = 1'b1;
                k[b] = 1'b1;
            end
            for (int f = 0; f < len; f++) run_frame_a(k, p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
